interp_line_buffer: RTL and testbench
=====================================

// Module: interp_line_buffer
// PURPOSE
//  Multi-line ring buffer feeding the bilinear scaler. Stores NUM_LINES video lines of up to
//  2**ADDR_WIDTH pixels. Returns the vertically adjacent pixel pair (top/bottom line, same column)
//  with 1-cycle latency. Sits between the capture pixel stream and the interpolation datapath.
//  Single clock domain.
// PARAMETERS
//  DATA_WIDTH  32  pixel width in bits
//  ADDR_WIDTH  11  column address width; max line length 2**ADDR_WIDTH
//  NUM_LINES   4   line slots; power of 2, >= 3
//  (localparams) SLOT_W = clog2(NUM_LINES), CNT_W = SLOT_W+1
// PORTS
//  clk            in   1           system clock
//  rst_n          in   1           reset, asynchronous, active-low
//  frame_start    in   1           synchronous clear of all pointers/counts (new frame)
//  wr_valid       in   1           write pixel valid
//  wr_ready       out  1           buffer can accept a pixel
//  wr_data        in   DATA_WIDTH  pixel
//  wr_last        in   1           last pixel of line; commits the line
//  wr_overflow    out  1           sticky: line exceeded 2**ADDR_WIDTH pixels
//  rd_valid       in   1           read request
//  rd_ready       out  1           request acceptable
//  rd_col         in   ADDR_WIDTH  column to read
//  rd_dup         in   1           bottom edge: read top line for both outputs
//  rd_release     in   1           pop oldest committed line
//  rd_data_top    out  DATA_WIDTH  pixel from oldest line (top_slot)
//  rd_data_bot    out  DATA_WIDTH  pixel from top_slot+1 (or top_slot if rd_dup)
//  rd_data_valid  out  1           rd_data_* valid
//  lines_avail    out  CNT_W       committed, unreleased lines
// BEHAVIOUR
//  Reset (rst_n=0, async): wr_slot=top_slot=col=0, lines_avail=0, wr_overflow=0, rd_data_valid=0.
//   Outputs after reset: wr_ready=1, rd_ready=0, rd_data_top/bot=0.
//  rd_data_top/bot forced to 0 whenever rd_data_valid=0.
//  wr_ready = (lines_avail < NUM_LINES), combinational. Write accepted on wr_valid&wr_ready:
//   bank[wr_slot][col] <= wr_data; col++.
//  wr_last on an accepted write: col<=0, wr_slot<=wr_slot+1 (mod NUM_LINES), lines_avail++.
//  Column overflow: at col==2**ADDR_WIDTH-1 without wr_last, the pixel is written, col holds, and
//   wr_overflow sets (sticky until frame_start or reset).
//  rd_ready = rd_dup ? (lines_avail>=1) : (lines_avail>=2).
//   Only committed lines count, so a partially written slot is never read.
//  Read accepted on rd_valid&rd_ready:
//   - top reads bank[top_slot][rd_col].
//   - bot reads bank[top_slot+1][rd_col], or the same bank when rd_dup=1.
//   - rd_data_valid=1 exactly one cycle later; one request per cycle; no backpressure on data.
//  rd_release with lines_avail!=0: top_slot++, lines_avail--. Ignored when lines_avail==0.
//  Release in the same cycle as an accepted read: the read uses the pre-release top_slot.
//  Commit and release in the same cycle: lines_avail unchanged, both pointers advance.
//  Writer can only reach a slot after release; a released slot's last read is already captured.
//   RAM is read-first, so no overwrite hazard.
//  frame_start: highest priority below reset. Clears wr_slot, top_slot, col, lines_avail,
//   wr_overflow. rd_data_valid<=0 next cycle; a read accepted in the same cycle is dropped.
//   A write in the same cycle is stored at slot 0 col 0, then col=1.
//  Throughput: 1 write + 1 read per clock sustained.
// STRUCTURE
//  interp_lb_defs.vh: clog2 function, SLOT_W/CNT_W derivation.
//  Sub-module interp_lb_bank: 2**ADDR_WIDTH x DATA_WIDTH simple dual-port RAM.
//   - Inferred, read-first, 1-cycle registered read, no output reg.
//   - Instantiated NUM_LINES times (generate).
//  Top level contains:
//   - write/read pointers and lines_avail counter;
//   - per-bank read-address steering: top and bot addresses are distinct banks unless rd_dup;
//   - registered slot selects driving two output muxes.
// TESTING
//  1. Reset, then write 3 lines of 8 px (data=line*16+col), read col 5
//     -> top=0x05, bot=0x15, 1 cycle later; lines_avail=3.
//  2. Fill NUM_LINES=4 lines -> wr_ready=0 and a held write is not stored.
//     rd_release -> wr_ready=1 next cycle; the 5th line lands in slot 0.
//  3. One line committed, rd_valid with rd_dup=0 -> rd_ready=0.
//     With rd_dup=1, col 2 -> top=bot=0x02.
//  4. Commit (wr_last) and rd_release in the same cycle at lines_avail=2
//     -> lines_avail stays 2; the next read returns lines 1/2.
//  5. Write 2049 px without wr_last at ADDR_WIDTH=11 -> wr_overflow=1, col holds at 2047.
//     frame_start -> wr_overflow=0, lines_avail=0.
//  6. Assert rst_n low during a read -> rd_data_valid=0 and data=0 immediately;
//     after release wr_ready=1, rd_ready=0.

Source files
------------

// File: rtl/interp_line_buffer_pkg.sv
// Shared helpers for the interpolation line buffer: slot/count width derivation.
package interp_line_buffer_pkg;

   function automatic int lb_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/interp_line_buffer_bank.sv
// One line slot: simple dual-port RAM, read-first, single registered read port.
module interp_line_buffer_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Read and write share the edge; the non-blocking write makes a same-address read return old data.
   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (re) rdata_q <= mem_q[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/interp_line_buffer.sv
// Ring of NUM_LINES line slots returning vertically adjacent pixel pairs, 1-cycle read latency.
module interp_line_buffer
   import interp_line_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int NUM_LINES  = 4,
   localparam int SLOT_W    = lb_clog2(NUM_LINES),
   localparam int CNT_W     = SLOT_W + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_last,
   output logic                  wr_overflow,
   input  logic                  rd_valid,
   output logic                  rd_ready,
   input  logic [ADDR_WIDTH-1:0] rd_col,
   input  logic                  rd_dup,
   input  logic                  rd_release,
   output logic [DATA_WIDTH-1:0] rd_data_top,
   output logic [DATA_WIDTH-1:0] rd_data_bot,
   output logic                  rd_data_valid,
   output logic [CNT_W-1:0]      lines_avail
);

   localparam logic [ADDR_WIDTH-1:0] COL_MAX = '1;

   logic [SLOT_W-1:0]     wr_slot_q, wr_slot_d, top_slot_q, top_slot_d;
   logic [SLOT_W-1:0]     top_sel_q, top_sel_d, bot_sel_q, bot_sel_d;
   logic [ADDR_WIDTH-1:0] col_q, col_d;
   logic [CNT_W-1:0]      lines_avail_q, lines_avail_d;
   logic                  wr_overflow_q, wr_overflow_d;
   logic                  rd_valid_q, rd_valid_d;

   logic                  wr_fire, rd_fire, commit, release_ok;
   logic [SLOT_W-1:0]     wr_slot_eff, bot_slot;
   logic [ADDR_WIDTH-1:0] col_eff;
   logic [CNT_W-1:0]      lines_base;
   logic [NUM_LINES-1:0]  bank_we, bank_re;
   logic [DATA_WIDTH-1:0] bank_rdata [NUM_LINES];

   assign wr_ready = (lines_avail_q < CNT_W'(NUM_LINES));
   assign rd_ready = rd_dup ? (lines_avail_q != '0) : (lines_avail_q >= CNT_W'(2));
   assign wr_fire  = wr_valid && wr_ready;
   assign rd_fire  = rd_valid && rd_ready;
   assign commit   = wr_fire && wr_last;
   assign bot_slot = rd_dup ? top_slot_q : top_slot_q + SLOT_W'(1);

   // frame_start rebases the write side so a same-cycle pixel lands at slot 0, column 0.
   assign wr_slot_eff = frame_start ? '0 : wr_slot_q;
   assign col_eff     = frame_start ? '0 : col_q;
   assign lines_base  = frame_start ? '0 : lines_avail_q;
   assign release_ok  = !frame_start && rd_release && (lines_avail_q != '0);

   always_comb begin
      wr_slot_d     = wr_slot_eff;
      col_d         = col_eff;
      top_slot_d    = frame_start ? '0 : top_slot_q;
      wr_overflow_d = frame_start ? 1'b0 : wr_overflow_q;
      lines_avail_d = lines_base;
      rd_valid_d    = rd_fire && !frame_start;
      top_sel_d     = top_sel_q;
      bot_sel_d     = bot_sel_q;
      if (wr_fire) begin
         if (wr_last) begin
            col_d     = '0;
            wr_slot_d = wr_slot_eff + SLOT_W'(1);
         end else if (col_eff == COL_MAX) begin
            wr_overflow_d = 1'b1;
         end else begin
            col_d = col_eff + ADDR_WIDTH'(1);
         end
      end
      if (release_ok) top_slot_d = top_slot_q + SLOT_W'(1);
      if (commit && !release_ok)      lines_avail_d = lines_base + CNT_W'(1);
      else if (!commit && release_ok) lines_avail_d = lines_base - CNT_W'(1);
      if (rd_fire) begin
         top_sel_d = top_slot_q;
         bot_sel_d = bot_slot;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_slot_q     <= '0;
         top_slot_q    <= '0;
         col_q         <= '0;
         lines_avail_q <= '0;
         wr_overflow_q <= 1'b0;
         rd_valid_q    <= 1'b0;
         top_sel_q     <= '0;
         bot_sel_q     <= '0;
      end else begin
         wr_slot_q     <= wr_slot_d;
         top_slot_q    <= top_slot_d;
         col_q         <= col_d;
         lines_avail_q <= lines_avail_d;
         wr_overflow_q <= wr_overflow_d;
         rd_valid_q    <= rd_valid_d;
         top_sel_q     <= top_sel_d;
         bot_sel_q     <= bot_sel_d;
      end
   end

   // All banks see the same column; only the top/bottom slots are enabled for a read.
   generate
      for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_bank
         assign bank_we[gi] = wr_fire && (wr_slot_eff == SLOT_W'(gi));
         assign bank_re[gi] = rd_fire && ((top_slot_q == SLOT_W'(gi)) || (bot_slot == SLOT_W'(gi)));
         interp_line_buffer_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
         ) u_bank (
            .clk  (clk),
            .we   (bank_we[gi]),
            .waddr(col_eff),
            .wdata(wr_data),
            .re   (bank_re[gi]),
            .raddr(rd_col),
            .rdata(bank_rdata[gi])
         );
      end
   endgenerate

   assign rd_data_valid = rd_valid_q;
   assign rd_data_top   = rd_valid_q ? bank_rdata[top_sel_q] : '0;
   assign rd_data_bot   = rd_valid_q ? bank_rdata[bot_sel_q] : '0;
   assign wr_overflow   = wr_overflow_q;
   assign lines_avail   = lines_avail_q;

endmodule

// File: tb/tb_interp_line_buffer.sv
// Directed bench for interp_line_buffer: one task per scenario, inline checks.
module tb_interp_line_buffer;

   localparam int DW = 32;
   localparam int AW = 11;
   localparam int NL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          frame_start = 1'b0;
   logic          wr_valid = 1'b0;
   logic          wr_ready;
   logic [DW-1:0] wr_data = '0;
   logic          wr_last = 1'b0;
   logic          wr_overflow;
   logic          rd_valid = 1'b0;
   logic          rd_ready;
   logic [AW-1:0] rd_col = '0;
   logic          rd_dup = 1'b0;
   logic          rd_release = 1'b0;
   logic [DW-1:0] rd_data_top, rd_data_bot;
   logic          rd_data_valid;
   logic [2:0]    lines_avail;

   int total = 0;
   int bad   = 0;

   interp_line_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
      .wr_overflow(wr_overflow), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_col(rd_col),
      .rd_dup(rd_dup), .rd_release(rd_release), .rd_data_top(rd_data_top),
      .rd_data_bot(rd_data_bot), .rd_data_valid(rd_data_valid), .lines_avail(lines_avail)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_line(input int base, input bit rel_last);
      for (int c = 0; c < 8; c++) begin
         wr_valid   = 1'b1;
         wr_data    = DW'(base + c);
         wr_last    = (c == 7);
         rd_release = rel_last && (c == 7);
         tick();
      end
      wr_valid = 1'b0; wr_last = 1'b0; rd_release = 1'b0;
      $display("write line base=0x%0h release_on_last=%0d lines_avail=%0d", base, rel_last, lines_avail);
   endtask

   task automatic do_read(input int col, input bit dup);
      rd_valid = 1'b1; rd_col = AW'(col); rd_dup = dup;
      tick();
      rd_valid = 1'b0; rd_dup = 1'b0;
      $display("read col=%0d dup=%0d -> valid=%0d top=0x%0h bot=0x%0h", col, dup, rd_data_valid, rd_data_top, rd_data_bot);
   endtask

   task automatic do_release();
      rd_release = 1'b1;
      tick();
      rd_release = 1'b0;
      $display("release -> lines_avail=%0d", lines_avail);
   endtask

   task automatic do_frame_start();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      $display("frame_start -> lines_avail=%0d overflow=%0d", lines_avail, wr_overflow);
   endtask

   task automatic test_reset();
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%0b exp=1", wr_ready); end
      total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL reset_rd_ready got=%0b exp=0", rd_ready); end
      total++; if (rd_data_valid !== 1'b0 || rd_data_top !== '0 || rd_data_bot !== '0) begin
         bad++; $display("FAIL reset_rd_data got=%0b/%0h/%0h exp=0/0/0", rd_data_valid, rd_data_top, rd_data_bot); end
      total++; if (lines_avail !== 3'd0 || wr_overflow !== 1'b0) begin
         bad++; $display("FAIL reset_counts got=%0d/%0b exp=0/0", lines_avail, wr_overflow); end
   endtask

   task automatic test_basic_read();
      for (int l = 0; l < 3; l++) write_line(l * 16, 1'b0);
      total++; if (lines_avail !== 3'd3) begin bad++; $display("FAIL basic_lines got=%0d exp=3", lines_avail); end
      total++; if (rd_ready !== 1'b1) begin bad++; $display("FAIL basic_rd_ready got=%0b exp=1", rd_ready); end
      total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL basic_pre_valid got=%0b exp=0", rd_data_valid); end
      do_read(5, 1'b0);
      total++; if (rd_data_valid !== 1'b1 || rd_data_top !== 32'h05 || rd_data_bot !== 32'h15) begin
         bad++; $display("FAIL basic_read got=%0b/%0h/%0h exp=1/5/15", rd_data_valid, rd_data_top, rd_data_bot); end
      tick();
      total++; if (rd_data_valid !== 1'b0 || rd_data_top !== '0) begin
         bad++; $display("FAIL basic_valid_drop got=%0b/%0h exp=0/0", rd_data_valid, rd_data_top); end
   endtask

   task automatic test_full();
      write_line(48, 1'b0);
      total++; if (wr_ready !== 1'b0 || lines_avail !== 3'd4) begin
         bad++; $display("FAIL full_ready got=%0b/%0d exp=0/4", wr_ready, lines_avail); end
      wr_valid = 1'b1; wr_data = 32'hDEAD; wr_last = 1'b1;
      tick();
      wr_valid = 1'b0; wr_last = 1'b0;
      $display("held write 0xDEAD while full -> lines_avail=%0d", lines_avail);
      total++; if (lines_avail !== 3'd4) begin bad++; $display("FAIL full_held_count got=%0d exp=4", lines_avail); end
      do_read(0, 1'b0);
      total++; if (rd_data_top !== 32'h00 || rd_data_bot !== 32'h10) begin
         bad++; $display("FAIL full_not_stored got=%0h/%0h exp=0/10", rd_data_top, rd_data_bot); end
      do_release();
      total++; if (wr_ready !== 1'b1 || lines_avail !== 3'd3) begin
         bad++; $display("FAIL full_release got=%0b/%0d exp=1/3", wr_ready, lines_avail); end
      write_line(64, 1'b0);
      do_release();
      do_release();
      do_read(6, 1'b0);
      total++; if (rd_data_top !== 32'h36 || rd_data_bot !== 32'h46) begin
         bad++; $display("FAIL full_wrap_slot0 got=%0h/%0h exp=36/46", rd_data_top, rd_data_bot); end
   endtask

   task automatic test_dup();
      do_frame_start();
      write_line(0, 1'b0);
      rd_valid = 1'b1; rd_dup = 1'b0; rd_col = AW'(2);
      #1;
      total++; if (rd_ready !== 1'b0) begin bad++; $display("FAIL dup_not_ready got=%0b exp=0", rd_ready); end
      tick();
      rd_valid = 1'b0;
      total++; if (rd_data_valid !== 1'b0) begin bad++; $display("FAIL dup_refused got=%0b exp=0", rd_data_valid); end
      do_read(2, 1'b1);
      total++; if (rd_data_valid !== 1'b1 || rd_data_top !== 32'h02 || rd_data_bot !== 32'h02) begin
         bad++; $display("FAIL dup_read got=%0b/%0h/%0h exp=1/2/2", rd_data_valid, rd_data_top, rd_data_bot); end
   endtask

   task automatic test_commit_release();
      do_frame_start();
      write_line(0, 1'b0);
      write_line(16, 1'b0);
      write_line(32, 1'b1);
      total++; if (lines_avail !== 3'd2) begin bad++; $display("FAIL cr_lines got=%0d exp=2", lines_avail); end
      do_read(3, 1'b0);
      total++; if (rd_data_top !== 32'h13 || rd_data_bot !== 32'h23) begin
         bad++; $display("FAIL cr_read got=%0h/%0h exp=13/23", rd_data_top, rd_data_bot); end
   endtask

   task automatic test_overflow();
      do_frame_start();
      for (int i = 0; i < 2049; i++) begin
         if (i == 2047) begin
            total++; if (wr_overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0b exp=0", wr_overflow); end
         end
         wr_valid = 1'b1; wr_data = DW'(i); wr_last = 1'b0;
         tick();
      end
      wr_valid = 1'b0;
      $display("wrote 2049 px without last -> overflow=%0b", wr_overflow);
      total++; if (wr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", wr_overflow); end
      wr_valid = 1'b1; wr_data = 32'hABC; wr_last = 1'b1;
      tick();
      wr_valid = 1'b0; wr_last = 1'b0;
      total++; if (lines_avail !== 3'd1 || wr_overflow !== 1'b1) begin
         bad++; $display("FAIL ovf_commit got=%0d/%0b exp=1/1", lines_avail, wr_overflow); end
      do_read(2047, 1'b1);
      total++; if (rd_data_top !== 32'hABC) begin bad++; $display("FAIL ovf_col_hold got=%0h exp=abc", rd_data_top); end
      do_read(2046, 1'b1);
      total++; if (rd_data_bot !== 32'h7FE) begin bad++; $display("FAIL ovf_col_2046 got=%0h exp=7fe", rd_data_bot); end
      do_frame_start();
      total++; if (wr_overflow !== 1'b0 || lines_avail !== 3'd0) begin
         bad++; $display("FAIL ovf_clear got=%0b/%0d exp=0/0", wr_overflow, lines_avail); end
   endtask

   task automatic test_async_reset();
      write_line(0, 1'b0);
      write_line(16, 1'b0);
      do_read(1, 1'b0);
      total++; if (rd_data_valid !== 1'b1 || rd_data_top !== 32'h01 || rd_data_bot !== 32'h11) begin
         bad++; $display("FAIL areset_pre got=%0b/%0h/%0h exp=1/1/11", rd_data_valid, rd_data_top, rd_data_bot); end
      rst_n = 1'b0;
      #1;
      $display("async reset asserted -> valid=%0b top=0x%0h", rd_data_valid, rd_data_top);
      total++; if (rd_data_valid !== 1'b0 || rd_data_top !== '0 || rd_data_bot !== '0) begin
         bad++; $display("FAIL areset_data got=%0b/%0h/%0h exp=0/0/0", rd_data_valid, rd_data_top, rd_data_bot); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      total++; if (wr_ready !== 1'b1 || rd_ready !== 1'b0 || lines_avail !== 3'd0) begin
         bad++; $display("FAIL areset_after got=%0b/%0b/%0d exp=1/0/0", wr_ready, rd_ready, lines_avail); end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      test_reset();
      test_basic_read();
      test_full();
      test_dup();
      test_commit_release();
      test_overflow();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
